// File: rtl/pbit_sample_voter_if.sv
// Measurement request and vote-result bundle for the p-bit sample voter.
// The master drives the request and the adder streams; the slave reports results.
interface pbit_sample_voter_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 10
);
  logic             start;
  logic [CNT_W-1:0] steps;
  logic [CNT_W-1:0] settle;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] s_in;
  logic             ovf_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] a_vote;
  logic [WIDTH-1:0] b_vote;
  logic [WIDTH-1:0] s_vote;
  logic             ovf_vote;
  logic [CNT_W-1:0] consistent_cnt;

  modport master (
    output start, steps, settle,
    output a_in, b_in, s_in, ovf_in,
    input  busy, done,
    input  a_vote, b_vote, s_vote,
    input  ovf_vote, consistent_cnt
  );

  modport slave (
    input  start, steps, settle,
    input  a_in, b_in, s_in, ovf_in,
    output busy, done,
    output a_vote, b_vote, s_vote,
    output ovf_vote, consistent_cnt
  );
endinterface

// File: rtl/pbit_sample_voter.sv
// Majority-vote readout of the stochastic adder streams over a window,
// after an optional burn-in, plus a count of self-consistent samples.
module pbit_sample_voter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 10
) (
  input logic                clk,
  input logic                reset,
  pbit_sample_voter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    ACCUM,
    VOTE
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] steps_q;
  logic [CNT_W-1:0] a_ones_q [WIDTH];
  logic [CNT_W-1:0] b_ones_q [WIDTH];
  logic [CNT_W-1:0] s_ones_q [WIDTH];
  logic [CNT_W-1:0] ovf_ones_q;
  logic [CNT_W-1:0] cons_q;

  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] a_vote_q;
  logic [WIDTH-1:0] b_vote_q;
  logic [WIDTH-1:0] s_vote_q;
  logic             ovf_vote_q;
  logic [CNT_W-1:0] cons_out_q;

  logic [WIDTH-1:0] a_vote_d;
  logic [WIDTH-1:0] b_vote_d;
  logic [WIDTH-1:0] s_vote_d;
  logic             ovf_vote_d;
  logic [WIDTH:0]   sum_w;
  logic             sum_ok;

  // Strict majority at CNT_W+1 bits: a tie votes 0.
  function automatic logic maj(
    input logic [CNT_W-1:0] ones,
    input logic [CNT_W-1:0] n
  );
    return {ones, 1'b0} > {1'b0, n};
  endfunction

  always_comb begin
    a_vote_d   = '0;
    b_vote_d   = '0;
    s_vote_d   = '0;
    ovf_vote_d = maj(ovf_ones_q, steps_q);
    for (int i = 0; i < WIDTH; i++) begin
      a_vote_d[i] = maj(a_ones_q[i], steps_q);
      b_vote_d[i] = maj(b_ones_q[i], steps_q);
      s_vote_d[i] = maj(s_ones_q[i], steps_q);
    end
  end

  assign sum_w  = {1'b0, bus.a_in} + {1'b0, bus.b_in};
  assign sum_ok = (sum_w == {bus.ovf_in, bus.s_in});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      steps_q    <= '0;
      ovf_ones_q <= '0;
      cons_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      a_vote_q   <= '0;
      b_vote_q   <= '0;
      s_vote_q   <= '0;
      ovf_vote_q <= 1'b0;
      cons_out_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        a_ones_q[i] <= '0;
        b_ones_q[i] <= '0;
        s_ones_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            steps_q    <= bus.steps;
            ovf_ones_q <= '0;
            cons_q     <= '0;
            busy_q     <= 1'b1;
            for (int i = 0; i < WIDTH; i++) begin
              a_ones_q[i] <= '0;
              b_ones_q[i] <= '0;
              s_ones_q[i] <= '0;
            end
            if (bus.settle != '0) begin
              state_q <= SETTLE;
              cnt_q   <= bus.settle;
            end else if (bus.steps != '0) begin
              state_q <= ACCUM;
              cnt_q   <= bus.steps;
            end else begin
              state_q <= VOTE;
            end
          end
        end
        SETTLE: begin
          if (cnt_q == CNT_W'(1)) begin
            cnt_q   <= steps_q;
            state_q <= (steps_q != '0) ? ACCUM : VOTE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ACCUM: begin
          for (int i = 0; i < WIDTH; i++) begin
            a_ones_q[i] <= a_ones_q[i] + CNT_W'(bus.a_in[i]);
            b_ones_q[i] <= b_ones_q[i] + CNT_W'(bus.b_in[i]);
            s_ones_q[i] <= s_ones_q[i] + CNT_W'(bus.s_in[i]);
          end
          ovf_ones_q <= ovf_ones_q + CNT_W'(bus.ovf_in);
          cons_q     <= cons_q + CNT_W'(sum_ok);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= VOTE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        VOTE: begin
          a_vote_q   <= a_vote_d;
          b_vote_q   <= b_vote_d;
          s_vote_q   <= s_vote_d;
          ovf_vote_q <= ovf_vote_d;
          cons_out_q <= cons_q;
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.a_vote         = a_vote_q;
  assign bus.b_vote         = b_vote_q;
  assign bus.s_vote         = s_vote_q;
  assign bus.ovf_vote       = ovf_vote_q;
  assign bus.consistent_cnt = cons_out_q;

endmodule

// File: tb/tb_pbit_sample_voter.sv
// Scoreboard bench for pbit_sample_voter: launches push expectations,
// a negedge monitor pops and compares on every done pulse.
module tb_pbit_sample_voter;
  localparam int W = 4;
  localparam int C = 10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pbit_sample_voter_if #(.WIDTH(W), .CNT_W(C)) bus ();

  pbit_sample_voter #(.WIDTH(W), .CNT_W(C)) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus)
  );

  typedef struct {
    int a;
    int b;
    int s;
    int o;
    int cnt;
    int cyc;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n === 1'b1 && bus.done === 1'b1) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL spurious_done: got done=1 want none (cycle %0d)",
                 cyc);
      end else begin
        e = q.pop_front();
        chk("a_vote", 32'(bus.a_vote), e.a);
        chk("b_vote", 32'(bus.b_vote), e.b);
        chk("s_vote", 32'(bus.s_vote), e.s);
        chk("ovf_vote", 32'(bus.ovf_vote), e.o);
        chk("consistent_cnt", 32'(bus.consistent_cnt), e.cnt);
        chk("done_latency", cyc, e.cyc);
        chk("busy_at_done", 32'(bus.busy), 0);
      end
    end
  end

  task automatic hold(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_in(input int a, input int b,
                        input int s, input int o);
    bus.a_in   = W'(a);
    bus.b_in   = W'(b);
    bus.s_in   = W'(s);
    bus.ovf_in = o[0];
  endtask

  // Issues start at the next edge (E0); returns at E0+#1.
  task automatic launch(input int st, input int se,
                        input int a, input int b, input int s,
                        input int o, input int cnt);
    exp_t e;
    bus.steps  = C'(st);
    bus.settle = C'(se);
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    e.a   = a;
    e.b   = b;
    e.s   = s;
    e.o   = o;
    e.cnt = cnt;
    e.cyc = cyc + se + st + 1;
    q.push_back(e);
  endtask

  task automatic wait_done(input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) return;
    end
    n_cmp++;
    n_err++;
    $display("FAIL done_timeout: got no done want done within %0d", bound);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_a"}, 32'(bus.a_vote), 0);
    chk({tag, "_b"}, 32'(bus.b_vote), 0);
    chk({tag, "_s"}, 32'(bus.s_vote), 0);
    chk({tag, "_ovf"}, 32'(bus.ovf_vote), 0);
    chk({tag, "_cnt"}, 32'(bus.consistent_cnt), 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.steps  = '0;
    bus.settle = '0;
    set_in(0, 0, 0, 0);
    hold(3);
    chk_zero("reset");
    rst_n = 1'b1;
    hold(2);

    // constant 1+7=8, long window
    set_in(1, 7, 8, 0);
    launch(300, 0, 1, 7, 8, 0, 300);
    wait_done(400);

    // alternating s bit0, even window -> tie votes 0
    set_in(0, 0, 0, 0);
    launch(4, 0, 0, 0, 0, 0, 2);
    for (int k = 1; k <= 4; k++) begin
      bus.s_in = (k % 2 == 1) ? 4'd1 : 4'd0;
      hold(1);
    end
    wait_done(10);

    // odd window starting on 0001 -> three ones, two consistent
    launch(5, 0, 0, 0, 1, 0, 2);
    for (int k = 1; k <= 5; k++) begin
      bus.s_in = (k % 2 == 1) ? 4'd1 : 4'd0;
      hold(1);
    end
    wait_done(10);

    // empty window, busy for a single cycle
    set_in(5, 5, 5, 1);
    launch(0, 0, 0, 0, 0, 0, 0);
    chk("steps0_busy", 32'(bus.busy), 1);
    wait_done(5);

    // overflow stream 9+8=17 after garbage burn-in
    launch(7, 2, 9, 8, 1, 1, 7);
    set_in(0, 0, 15, 1);
    hold(2);
    set_in(9, 8, 1, 1);
    wait_done(20);

    // burn-in garbage excluded
    launch(20, 5, 3, 9, 12, 0, 20);
    set_in(15, 15, 0, 0);
    hold(5);
    set_in(3, 9, 12, 0);
    wait_done(40);

    // reset mid-accumulation abandons the run
    set_in(7, 7, 14, 0);
    launch(100, 0, 7, 7, 14, 0, 100);
    hold(40);
    rst_n = 1'b0;
    #1;
    chk_zero("midreset");
    void'(q.pop_back());
    hold(3);
    rst_n = 1'b1;
    hold(120);
    set_in(2, 3, 5, 0);
    launch(10, 0, 2, 3, 5, 0, 10);
    wait_done(20);

    // start during ACCUM must be ignored
    set_in(6, 5, 11, 0);
    launch(50, 0, 6, 5, 11, 0, 50);
    hold(20);
    bus.steps = C'(3);
    bus.start = 1'b1;
    set_in(6, 5, 11, 0);
    hold(1);
    bus.start = 1'b0;
    wait_done(60);
    hold(60);

    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
